// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the store-and-forward AXI-Stream packet FIFO.
package axis_fifo_pkg;

   // Write-side FSM states; W_DROP is only reachable when dropping is built in.
   typedef enum logic [0:0] {
      W_PASS = 1'b0,
      W_DROP = 1'b1
   } wr_state_t;

   localparam int DROP_CNT_BITS = 16;

   // Width of one stored beat: {tlast, tdata, tuser, tkeep}.
   function automatic int axis_word_bits(input int bytes, input int user);
      return 8 * bytes + user + 1 + bytes;
   endfunction

endpackage

// File: rtl/axis_fifo_pkt_if.sv
// AXI-Stream bus bundle; master drives payload/tvalid, slave drives tready.
interface axis_fifo_pkt_if #(
   parameter int BYTES     = 1,
   parameter int USER_BITS = 1
);
   logic [8*BYTES-1:0]   tdata;
   logic [USER_BITS-1:0] tuser;
   logic [BYTES-1:0]     tkeep;
   logic                 tlast;
   logic                 tvalid;
   logic                 tready;

   modport master (output tdata, tuser, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tuser, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat memory: one write port, one read port with registered read.
// The read register doubles as the FIFO output data register, so it only
// updates when rd_en is high and otherwise holds the presented beat.
module axis_fifo_ram #(
   parameter int WIDTH      = 8,
   parameter int LOG2_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [LOG2_DEPTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [LOG2_DEPTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);
   logic [WIDTH-1:0] mem [2**LOG2_DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Write port plus registered read port.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/axis_fifo_pkt.sv
// Store-and-forward AXI-Stream packet FIFO.
// A packet becomes visible at the output only once its tlast beat is stored
// (commit_ptr marks the end of the last complete packet).
// Optional feature macro AXIS_FIFO_PKT_DROP_EN: input never backpressures;
// a packet that does not fit is discarded and counted in drop_count_o.
module axis_fifo_pkt
   import axis_fifo_pkg::*;
#(
   parameter int AXIS_BYTES     = 1,
   parameter int AXIS_USER_BITS = 1,
   parameter int LOG2_DEPTH     = 8,
   parameter int ALMOST_FULL    = 2**LOG2_DEPTH - 4
) (
   input  logic                     clk,
   input  logic                     aresetn,
   axis_fifo_pkt_if.slave           axis_i,
   axis_fifo_pkt_if.master          axis_o,
   output logic [LOG2_DEPTH:0]      level_o,
   output logic [LOG2_DEPTH:0]      pkt_count_o,
   output logic                     almost_full_o,
   output logic [DROP_CNT_BITS-1:0] drop_count_o
);
   localparam int WORD_BITS = axis_word_bits(AXIS_BYTES, AXIS_USER_BITS);
   localparam int PTR_BITS  = LOG2_DEPTH + 1;
   localparam logic [PTR_BITS-1:0] DEPTH_V = PTR_BITS'(1) << LOG2_DEPTH;

   logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0]  commit_ptr_q, commit_ptr_d;
   logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_BITS-1:0]  pkt_count_q, pkt_count_d;
   logic                 tvalid_q, tvalid_d;
   logic [PTR_BITS-1:0]  level;
   logic                 full;
   logic                 wr_en;
   logic                 rewind;
   logic                 commit_inc;
   logic                 rd_load;
   logic                 out_last_hs;
   logic [WORD_BITS-1:0] wr_word;
   logic [WORD_BITS-1:0] rd_word;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign full    = (level == DEPTH_V);
   assign wr_word = {axis_i.tlast, axis_i.tdata, axis_i.tuser, axis_i.tkeep};

`ifdef AXIS_FIFO_PKT_DROP_EN
   wr_state_t                state_q, state_d;
   logic [DROP_CNT_BITS-1:0] drop_count_q, drop_count_d;
   logic                     drop_inc;

   // Write FSM: pass beats through, or discard the rest of a packet that overflowed.
   always_comb begin
      state_d  = state_q;
      wr_en    = 1'b0;
      rewind   = 1'b0;
      drop_inc = 1'b0;
      if (axis_i.tvalid) begin
         unique case (state_q)
            W_PASS: begin
               if (full) begin
                  rewind = 1'b1;
                  if (axis_i.tlast) drop_inc = 1'b1;
                  else              state_d  = W_DROP;
               end else begin
                  wr_en = 1'b1;
               end
            end
            W_DROP: begin
               if (axis_i.tlast) begin
                  drop_inc = 1'b1;
                  state_d  = W_PASS;
               end
            end
            default: state_d = W_PASS;
         endcase
      end
      drop_count_d = (drop_inc && (drop_count_q != '1)) ? drop_count_q + 1'b1 : drop_count_q;
   end

   // FSM state and saturating drop counter.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= W_PASS;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign axis_i.tready = 1'b1;
   assign drop_count_o  = drop_count_q;
`else
   // Backpressure mode: accept whenever there is room.
   always_comb begin
      wr_en  = axis_i.tvalid && !full;
      rewind = 1'b0;
   end

   assign axis_i.tready = !full;
   assign drop_count_o  = '0;
`endif

   // Pointer, packet-count and output-valid next-state logic.
   always_comb begin
      commit_inc   = wr_en && axis_i.tlast;
      rd_load      = (rd_ptr_q != commit_ptr_q) && (!tvalid_q || axis_o.tready);
      out_last_hs  = tvalid_q && axis_o.tready && axis_o.tlast;

      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      if (rewind) begin
         wr_ptr_d = commit_ptr_q;
      end else if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (axis_i.tlast) commit_ptr_d = wr_ptr_q + 1'b1;
      end

      rd_ptr_d = rd_load ? rd_ptr_q + 1'b1 : rd_ptr_q;

      tvalid_d = tvalid_q;
      if (rd_load)             tvalid_d = 1'b1;
      else if (axis_o.tready)  tvalid_d = 1'b0;

      unique case ({commit_inc, out_last_hs})
         2'b10:   pkt_count_d = pkt_count_q + 1'b1;
         2'b01:   pkt_count_d = pkt_count_q - 1'b1;
         default: pkt_count_d = pkt_count_q;
      endcase
   end

   // Pointers, packet count and output valid; tvalid clears asynchronously.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         pkt_count_q  <= '0;
         tvalid_q     <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         pkt_count_q  <= pkt_count_d;
         tvalid_q     <= tvalid_d;
      end
   end

   axis_fifo_ram #(
      .WIDTH      (WORD_BITS),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q[LOG2_DEPTH-1:0]),
      .wr_data (wr_word),
      .rd_en   (rd_load),
      .rd_addr (rd_ptr_q[LOG2_DEPTH-1:0]),
      .rd_data (rd_word)
   );

   assign axis_o.tvalid = tvalid_q;
   assign axis_o.tkeep  = rd_word[AXIS_BYTES-1:0];
   assign axis_o.tuser  = rd_word[AXIS_BYTES +: AXIS_USER_BITS];
   assign axis_o.tdata  = rd_word[AXIS_BYTES+AXIS_USER_BITS +: 8*AXIS_BYTES];
   assign axis_o.tlast  = rd_word[WORD_BITS-1];

   assign level_o       = level;
   assign pkt_count_o   = pkt_count_q;
   assign almost_full_o = (int'(level) >= ALMOST_FULL);
endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Bench for axis_fifo_pkt: directed scenarios plus random traffic against a
// queue-based reference model (beats in memory, committed count, output slot).
module tb_axis_fifo_pkt;
   localparam int BYTES = 2;
   localparam int USER  = 2;
   localparam int L2D   = 2;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
`ifdef AXIS_FIFO_PKT_DROP_EN
   localparam bit DROP_BUILD = 1'b1;
`else
   localparam bit DROP_BUILD = 1'b0;
`endif

   typedef struct packed {
      logic        last;
      logic [15:0] data;
      logic [1:0]  user;
      logic [1:0]  keep;
   } beat_t;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [L2D:0] level, pkt_count;
   logic        almost_full;
   logic [15:0] drop_count;

   always #5 clk = ~clk;

   axis_fifo_pkt_if #(.BYTES(BYTES), .USER_BITS(USER)) s_if ();
   axis_fifo_pkt_if #(.BYTES(BYTES), .USER_BITS(USER)) m_if ();

   axis_fifo_pkt #(
      .AXIS_BYTES     (BYTES),
      .AXIS_USER_BITS (USER),
      .LOG2_DEPTH     (L2D),
      .ALMOST_FULL    (AF)
   ) dut (
      .clk           (clk),
      .aresetn       (aresetn),
      .axis_i        (s_if),
      .axis_o        (m_if),
      .level_o       (level),
      .pkt_count_o   (pkt_count),
      .almost_full_o (almost_full),
      .drop_count_o  (drop_count)
   );

   int n_vec = 0;
   int n_err = 0;
   int n_out_beats = 0;
   int n_out_pkts = 0;

   // reference model state
   beat_t mq[$];
   int    n_commit;
   bit    m_valid;
   beat_t m_out;
   int    m_pkt;
   int    m_drop;
   bit    m_dropping;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      n_commit   = 0;
      m_valid    = 1'b0;
      m_pkt      = 0;
      m_drop     = 0;
      m_dropping = 1'b0;
   endtask

   task automatic check_outputs();
      check_val("tvalid", 64'(m_if.tvalid), 64'(m_valid));
      if (m_valid)
         check_val("beat", 64'({m_if.tlast, m_if.tdata, m_if.tuser, m_if.tkeep}), 64'(m_out));
      check_val("level", 64'(level), 64'(mq.size()));
      check_val("pkt_count", 64'(pkt_count), 64'(m_pkt));
      check_val("almost_full", 64'(almost_full), 64'(mq.size() >= AF));
      check_val("drop_count", 64'(drop_count), 64'(m_drop));
   endtask

   function automatic beat_t rand_beat(input bit last);
      beat_t b;
      b.last = last;
      b.data = 16'($urandom);
      b.user = 2'($urandom);
      b.keep = 2'($urandom);
      return b;
   endfunction

   // One clock cycle: drive inputs, check pre-edge outputs, clock, advance model.
   task automatic step(input bit iv, input beat_t ib, input bit ordy, output bit acc);
      bit full, iready, load;
      s_if.tvalid = iv;
      s_if.tlast  = ib.last;
      s_if.tdata  = ib.data;
      s_if.tuser  = ib.user;
      s_if.tkeep  = ib.keep;
      m_if.tready = ordy;
      full   = (mq.size() == DEPTH);
      iready = DROP_BUILD || !full;
      check_outputs();
      check_val("tready", 64'(s_if.tready), 64'(iready));
      acc = iv && iready;
      if (m_if.tvalid && ordy) begin
         n_out_beats++;
         if (m_if.tlast) n_out_pkts++;
      end
      @(posedge clk);
      #1;
      if (m_valid && ordy && m_out.last) m_pkt--;
      load = (n_commit > 0) && (!m_valid || ordy);
      if (load) begin
         m_out = mq.pop_front();
         n_commit--;
         m_valid = 1'b1;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      if (iv) begin
`ifdef AXIS_FIFO_PKT_DROP_EN
         if (m_dropping) begin
            if (ib.last) begin
               if (m_drop < 65535) m_drop++;
               m_dropping = 1'b0;
            end
         end else if (full) begin
            while (mq.size() > n_commit) mq.delete(mq.size() - 1);
            if (ib.last) begin
               if (m_drop < 65535) m_drop++;
            end else begin
               m_dropping = 1'b1;
            end
         end else begin
            mq.push_back(ib);
            if (ib.last) begin n_commit = mq.size(); m_pkt++; end
         end
`else
         if (!full) begin
            mq.push_back(ib);
            if (ib.last) begin n_commit = mq.size(); m_pkt++; end
         end
`endif
      end
   endtask

   task automatic idle(input int n, input bit ordy);
      bit acc;
      beat_t z;
      z = '0;
      for (int i = 0; i < n; i++) step(1'b0, z, ordy, acc);
   endtask

   // Offer one beat until accepted, with a bounded number of tries.
   task automatic send_beat(input beat_t b, input bit ordy);
      bit acc;
      int tries;
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 20) begin
         step(1'b1, b, ordy, acc);
         tries++;
      end
      check_val("send_timeout", 64'(acc), 64'(1));
   endtask

   task automatic send_pkt(input int len, input bit ordy);
      for (int i = 0; i < len; i++) send_beat(rand_beat(i == len - 1), ordy);
   endtask

   initial begin
      beat_t t1[3];
      beat_t got;
      int    ngot, p0, b0, d0, sent_beats, pk, bi, len, cyc;
      bit    acc, iv, ordy;
      beat_t cur;

      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
      s_if.tuser = '0;    s_if.tkeep = '0;   m_if.tready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 aresetn = 1'b1;
      check_outputs();

      // T1: 3-beat packet, nothing shown until committed, then back-to-back
      for (int i = 0; i < 3; i++) t1[i] = rand_beat(i == 2);
      for (int i = 0; i < 3; i++) begin
         send_beat(t1[i], 1'b1);
         check_val("t1_hidden", 64'(m_if.tvalid), 64'(0));
      end
      ngot = 0;
      for (int i = 0; i < 5; i++) begin
         idle(1, 1'b1);
         if (i == 0) check_val("t1_first_valid", 64'(m_if.tvalid), 64'(1));
         if (m_if.tvalid) begin
            got = {m_if.tlast, m_if.tdata, m_if.tuser, m_if.tkeep};
            if (ngot < 3) check_val("t1_beat", 64'(got), 64'(t1[ngot]));
            ngot++;
         end
      end
      check_val("t1_count", 64'(ngot), 64'(3));

      // T2: five 1-beat packets with output stalled; memory fills, then drain
      for (int i = 0; i < 5; i++) send_pkt(1, 1'b0);
      check_val("t2_level", 64'(level), 64'(4));
      check_val("t2_pkts", 64'(pkt_count), 64'(5));
      check_val("t2_tready", 64'(s_if.tready), 64'(DROP_BUILD));
      check_val("t2_almost_full", 64'(almost_full), 64'(1));
      p0 = n_out_pkts;
      idle(10, 1'b1);
      check_val("t2_delivered", 64'(n_out_pkts - p0), 64'(5));
      check_val("t2_empty", 64'(pkt_count), 64'(0));

      // T3: random traffic, 1000 packets of 1..4 beats
      p0 = n_out_pkts; b0 = n_out_beats; d0 = m_drop;
      sent_beats = 0; pk = 0; bi = 0; cyc = 0;
      len = $urandom_range(1, 4);
      cur = rand_beat(len == 1);
      while (pk < 1000 && cyc < 40000) begin
         iv   = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 7);
         step(iv, cur, ordy, acc);
         cyc++;
         if (acc) begin
            sent_beats++;
            bi++;
            if (bi == len) begin
               pk++;
               bi = 0;
               len = $urandom_range(1, 4);
            end
            cur = rand_beat(bi == len - 1);
         end
      end
      check_val("t3_all_sent", 64'(pk), 64'(1000));
      idle(40, 1'b1);
      check_val("t3_pkts", 64'(n_out_pkts - p0), 64'(1000 - (m_drop - d0)));
      if (m_drop == d0)
         check_val("t3_beats", 64'(n_out_beats - b0), 64'(sent_beats));

`ifdef AXIS_FIFO_PKT_DROP_EN
      // T4: oversized packet dropped, following packet delivered
      p0 = n_out_pkts; d0 = m_drop;
      send_pkt(6, 1'b1);
      send_pkt(2, 1'b1);
      idle(8, 1'b1);
      check_val("t4_drop", 64'(drop_count), 64'(d0 + 1));
      check_val("t4_delivered", 64'(n_out_pkts - p0), 64'(1));

      // T5: committed packet stalled, overflowing packet dropped around it
      p0 = n_out_pkts; d0 = m_drop;
      send_pkt(2, 1'b0);
      idle(2, 1'b0);
      send_pkt(4, 1'b0);
      check_val("t5_drop", 64'(drop_count), 64'(d0 + 1));
      idle(8, 1'b1);
      check_val("t5_delivered", 64'(n_out_pkts - p0), 64'(1));
`endif

      // T6: asynchronous reset mid-packet
      send_pkt(1, 1'b0);
      idle(2, 1'b0);
      check_val("t6_pre_valid", 64'(m_if.tvalid), 64'(1));
      send_beat(rand_beat(1'b0), 1'b0);
      send_beat(rand_beat(1'b0), 1'b0);
      #2 aresetn = 1'b0;
      s_if.tvalid = 1'b0;
      #1;
      check_val("t6_async_tvalid", 64'(m_if.tvalid), 64'(0));
      check_val("t6_level", 64'(level), 64'(0));
      check_val("t6_pkts", 64'(pkt_count), 64'(0));
      model_reset();
      @(posedge clk);
      #1 aresetn = 1'b1;
      check_outputs();
      p0 = n_out_pkts;
      send_pkt(2, 1'b1);
      idle(6, 1'b1);
      check_val("t6_after", 64'(n_out_pkts - p0), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
